// File: rtl/seg_pkg.sv
// rtl/seg_pkg.sv - active-low seven-segment patterns shared with the hex encoder
package seg_pkg;

  localparam int NIBBLE_W = 4;
  localparam int SEG_W    = 7;

  // bit 6 = segment g ... bit 0 = segment a, 0 lights the segment
  localparam logic [SEG_W-1:0] SEG_PAT_0 = 7'b1000000;
  localparam logic [SEG_W-1:0] SEG_PAT_1 = 7'b1111001;
  localparam logic [SEG_W-1:0] SEG_PAT_2 = 7'b0100100;
  localparam logic [SEG_W-1:0] SEG_PAT_3 = 7'b0110000;
  localparam logic [SEG_W-1:0] SEG_PAT_4 = 7'b0011001;
  localparam logic [SEG_W-1:0] SEG_PAT_5 = 7'b0010010;
  localparam logic [SEG_W-1:0] SEG_PAT_6 = 7'b0000010;
  localparam logic [SEG_W-1:0] SEG_PAT_7 = 7'b1111000;
  localparam logic [SEG_W-1:0] SEG_PAT_8 = 7'b0000000;
  localparam logic [SEG_W-1:0] SEG_PAT_9 = 7'b0010000;
  localparam logic [SEG_W-1:0] SEG_PAT_A = 7'b0001000;
  localparam logic [SEG_W-1:0] SEG_PAT_B = 7'b0000011;
  localparam logic [SEG_W-1:0] SEG_PAT_C = 7'b1000110;
  localparam logic [SEG_W-1:0] SEG_PAT_D = 7'b0100001;
  localparam logic [SEG_W-1:0] SEG_PAT_E = 7'b0000110;
  localparam logic [SEG_W-1:0] SEG_PAT_F = 7'b1111111;

  // The encoder shows F as a dark digit, so blank and F share one pattern
  localparam logic [SEG_W-1:0] SEG_BLANK = SEG_PAT_F;

endpackage

// File: rtl/seg_scan_decoder_if.sv
// rtl/seg_scan_decoder_if.sv - display bus snoop inputs and decoded result outputs
interface seg_scan_decoder_if #(
  parameter int NDIG = 8
);
  import seg_pkg::*;

  localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;

  logic [NDIG-1:0]          an_n;
  logic [SEG_W-1:0]         seg_n;
  logic                     clear;
  logic [NIBBLE_W*NDIG-1:0] values;
  logic [NDIG-1:0]          valid;
  logic                     err_pulse;
  logic [IW-1:0]            err_digit;
  logic                     frame_done;

  modport master (
    output an_n, seg_n, clear,
    input  values, valid, err_pulse, err_digit, frame_done
  );

  modport slave (
    input  an_n, seg_n, clear,
    output values, valid, err_pulse, err_digit, frame_done
  );

endinterface

// File: rtl/seg_pattern_lookup.sv
// rtl/seg_pattern_lookup.sv - combinational segment pattern to nibble decode
module seg_pattern_lookup
  import seg_pkg::*;
(
  input  logic [SEG_W-1:0]    seg_n,
  output logic [NIBBLE_W-1:0] nibble,
  output logic                legal
);

  always_comb begin
    nibble = '0;
    legal  = 1'b1;
    case (seg_n)
      SEG_PAT_0: nibble = 4'h0;
      SEG_PAT_1: nibble = 4'h1;
      SEG_PAT_2: nibble = 4'h2;
      SEG_PAT_3: nibble = 4'h3;
      SEG_PAT_4: nibble = 4'h4;
      SEG_PAT_5: nibble = 4'h5;
      SEG_PAT_6: nibble = 4'h6;
      SEG_PAT_7: nibble = 4'h7;
      SEG_PAT_8: nibble = 4'h8;
      SEG_PAT_9: nibble = 4'h9;
      SEG_PAT_A: nibble = 4'hA;
      SEG_PAT_B: nibble = 4'hB;
      SEG_PAT_C: nibble = 4'hC;
      SEG_PAT_D: nibble = 4'hD;
      SEG_PAT_E: nibble = 4'hE;
      SEG_PAT_F: nibble = 4'hF;
      default:   legal  = 1'b0;
    endcase
  end

endmodule

// File: rtl/seg_scan_decoder.sv
// rtl/seg_scan_decoder.sv - recovers per-digit nibbles from a multiplexed active-low display
module seg_scan_decoder
  import seg_pkg::*;
#(
  parameter int NDIG   = 8,
  parameter int STABLE = 4
) (
  input  logic               clk,
  input  logic               clrn,
  seg_scan_decoder_if.slave  bus
);

  localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam int CW = $clog2(STABLE);
  localparam logic [CW-1:0] CNT_MAX = CW'(STABLE - 1);

  logic [NDIG-1:0]          an_q, an_p;
  logic [SEG_W-1:0]         seg_q, seg_p;
  logic [CW-1:0]            cnt;
  logic                     captured;
  logic [NDIG-1:0]          mask;
  logic [NIBBLE_W*NDIG-1:0] values_r;
  logic [NDIG-1:0]          valid_r;
  logic                     err_pulse_r;
  logic [IW-1:0]            err_digit_r;
  logic                     frame_done_r;

  int                       zeros;
  logic [IW-1:0]            idx;
  logic                     active;
  logic                     same;
  logic [CW-1:0]            cnt_next;
  logic                     capture;
  logic [NIBBLE_W-1:0]      nib;
  logic                     legal;
  logic [NDIG-1:0]          mask_next;

  seg_pattern_lookup u_lookup (
    .seg_n  (seg_q),
    .nibble (nib),
    .legal  (legal)
  );

  // Only a single selected anode names a digit; idle and ghosted multi-selects are ignored
  always_comb begin
    zeros = 0;
    idx   = '0;
    for (int i = NDIG - 1; i >= 0; i--) begin
      if (!an_q[i]) begin
        zeros = zeros + 1;
        idx   = IW'(i);
      end
    end
    active = (zeros == 1);
  end

  // Capture fires on the edge where the counter lands on STABLE-1 with a fresh dwell
  always_comb begin
    same      = (an_q == an_p) && (seg_q == seg_p);
    cnt_next  = '0;
    if (same) cnt_next = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;
    capture   = active && same && (cnt_next == CNT_MAX) && !captured;
    mask_next = mask | (NDIG'(1) << idx);
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      an_q         <= '0;
      an_p         <= '0;
      seg_q        <= '0;
      seg_p        <= '0;
      cnt          <= '0;
      captured     <= 1'b0;
      mask         <= '0;
      values_r     <= '0;
      valid_r      <= '0;
      err_pulse_r  <= 1'b0;
      err_digit_r  <= '0;
      frame_done_r <= 1'b0;
    end else begin
      an_q         <= bus.an_n;
      seg_q        <= bus.seg_n;
      an_p         <= an_q;
      seg_p        <= seg_q;
      err_pulse_r  <= 1'b0;
      frame_done_r <= 1'b0;

      if (!active) begin
        cnt      <= '0;
        captured <= 1'b0;
      end else begin
        cnt <= cnt_next;
        if (!same)        captured <= 1'b0;
        else if (capture) captured <= 1'b1;
      end

      if (capture) begin
        if (legal) begin
          values_r[NIBBLE_W*int'(idx) +: NIBBLE_W] <= nib;
        end else begin
          err_pulse_r <= 1'b1;
          err_digit_r <= idx;
        end
      end

      // clear beats a coincident capture for flags and frame tracking, not for values
      if (bus.clear) begin
        valid_r <= '0;
        mask    <= '0;
      end else if (capture) begin
        valid_r[idx] <= legal;
        if (&mask_next) begin
          frame_done_r <= 1'b1;
          mask         <= '0;
        end else begin
          mask <= mask_next;
        end
      end
    end
  end

  assign bus.values     = values_r;
  assign bus.valid      = valid_r;
  assign bus.err_pulse  = err_pulse_r;
  assign bus.err_digit  = err_digit_r;
  assign bus.frame_done = frame_done_r;

endmodule

// File: tb/tb_seg_scan_decoder.sv
// tb/tb_seg_scan_decoder.sv - directed vector bench for seg_scan_decoder
module tb_seg_scan_decoder;

  typedef struct {
    int         digit;
    logic [6:0] seg;
    logic [3:0] nib;
    int         fd;
  } vec_t;

  logic clk;
  logic clrn;
  int   total;
  int   bad;
  int   ep_cnt;
  int   fd_cnt;

  seg_scan_decoder_if #(.NDIG(8)) bus ();

  seg_scan_decoder #(.NDIG(8), .STABLE(4)) dut (
    .clk  (clk),
    .clrn (clrn),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse counters sampled mid-cycle
  always @(negedge clk) begin
    if (bus.err_pulse === 1'b1)  ep_cnt = ep_cnt + 1;
    if (bus.frame_done === 1'b1) fd_cnt = fd_cnt + 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total = total + 1;
    if (act !== exp) begin
      bad = bad + 1;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive(input int digit, input logic [6:0] seg, input int cycles);
    logic [7:0] one;
    one = 8'b1;
    bus.an_n  = ~(one << digit);
    bus.seg_n = seg;
    tick(cycles);
  endtask

  logic [6:0] pat [16];
  vec_t       vt  [16];
  int         ep0;
  int         fd0;

  initial begin
    pat = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
            7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
            7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
            7'b1000110, 7'b0100001, 7'b0000110, 7'b1111111};
    for (int i = 0; i < 16; i++) begin
      vt[i].digit = i % 8;
      vt[i].seg   = pat[i];
      vt[i].nib   = 4'(i);
      vt[i].fd    = (i >= 15) ? 2 : ((i >= 7) ? 1 : 0);
    end

    total = 0; bad = 0; ep_cnt = 0; fd_cnt = 0;
    clrn = 1'b0;
    bus.an_n = 8'hFF; bus.seg_n = 7'h7F; bus.clear = 1'b0;
    tick(2);
    chk("rst_values", bus.values, 32'h0);
    chk("rst_valid", 32'(bus.valid), 32'h0);
    chk("rst_err_pulse", 32'(bus.err_pulse), 32'h0);
    chk("rst_err_digit", 32'(bus.err_digit), 32'h0);
    chk("rst_frame_done", 32'(bus.frame_done), 32'h0);

    // Capture, then async reset mid-dwell, then the 5-cycle recapture
    clrn = 1'b1;
    drive(0, 7'b0110000, 6);
    chk("pre_rst_nib0", 32'(bus.values[3:0]), 32'h3);
    #2 clrn = 1'b0;
    #1;
    chk("async_rst_values", bus.values, 32'h0);
    chk("async_rst_valid", 32'(bus.valid), 32'h0);
    tick(2);
    clrn = 1'b1;
    tick(4);
    chk("lat_before_valid", 32'(bus.valid), 32'h0);
    tick(1);
    chk("lat_valid", 32'(bus.valid), 32'h01);
    chk("lat_nib0", 32'(bus.values[3:0]), 32'h3);
    tick(1);
    chk("lat_no_err", 32'(ep_cnt), 32'h0);
    chk("lat_no_frame", 32'(fd_cnt), 32'h0);

    // Glitch filter on digit 2
    drive(2, 7'b0000010, 3);
    drive(2, 7'b1111000, 4);
    chk("glitch_not_yet", 32'(bus.valid[2]), 32'h0);
    tick(1);
    chk("glitch_nib2", 32'(bus.values[11:8]), 32'h7);
    chk("glitch_valid2", 32'(bus.valid[2]), 32'h1);

    // Illegal pattern on digit 5 after a legal 9
    drive(5, 7'b0010000, 6);
    chk("ill_pre_nib5", 32'(bus.values[23:20]), 32'h9);
    ep0 = ep_cnt;
    drive(5, 7'b1010101, 6);
    chk("ill_one_pulse", 32'(ep_cnt - ep0), 32'h1);
    chk("ill_err_digit", 32'(bus.err_digit), 32'h5);
    chk("ill_valid5", 32'(bus.valid[5]), 32'h0);
    chk("ill_nib5_kept", 32'(bus.values[23:20]), 32'h9);

    // Plain clear: flags drop, values stay
    bus.an_n = 8'hFF;
    bus.clear = 1'b1;
    tick(1);
    bus.clear = 1'b0;
    tick(1);
    chk("clr_valid", 32'(bus.valid), 32'h0);
    chk("clr_values", bus.values, 32'h00900703);

    // Two full scans from the vector table
    fd0 = fd_cnt;
    for (int i = 0; i < 16; i++) begin
      drive(vt[i].digit, vt[i].seg, 8);
      chk($sformatf("scan%0d_nib", i), 32'(bus.values[4*vt[i].digit +: 4]), 32'(vt[i].nib));
      chk($sformatf("scan%0d_valid", i), 32'(bus.valid[vt[i].digit]), 32'h1);
      chk($sformatf("scan%0d_frames", i), 32'(fd_cnt - fd0), 32'(vt[i].fd));
      if (i == 7) begin
        chk("scan1_values", bus.values, 32'h76543210);
        chk("scan1_valid", 32'(bus.valid), 32'hFF);
      end
    end
    chk("scan2_values", bus.values, 32'hFEDCBA98);

    // Idle and multi-select produce nothing
    ep0 = ep_cnt; fd0 = fd_cnt;
    bus.an_n = 8'hFF; bus.seg_n = 7'b0000000;
    tick(10);
    bus.an_n = 8'b11110011;
    tick(10);
    chk("idle_values", bus.values, 32'hFEDCBA98);
    chk("idle_valid", 32'(bus.valid), 32'hFF);
    chk("idle_no_err", 32'(ep_cnt - ep0), 32'h0);
    chk("idle_no_frame", 32'(fd_cnt - fd0), 32'h0);

    // Clear colliding with digit 7's frame-completing capture
    for (int k = 0; k < 7; k++) drive(k, pat[k], 8);
    chk("coll_pre_frames", 32'(fd_cnt - fd0), 32'h0);
    drive(7, 7'b0000000, 4);
    bus.clear = 1'b1;
    tick(1);
    bus.clear = 1'b0;
    chk("coll_valid", 32'(bus.valid), 32'h0);
    chk("coll_values", bus.values, 32'h86543210);
    tick(3);
    chk("coll_no_frame", 32'(fd_cnt - fd0), 32'h0);
    drive(0, pat[5], 8);
    chk("post_coll_valid", 32'(bus.valid), 32'h01);
    chk("post_coll_nib0", 32'(bus.values[3:0]), 32'h5);
    chk("post_coll_no_frame", 32'(fd_cnt - fd0), 32'h0);
    chk("post_coll_no_err", 32'(ep_cnt - ep0), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seg_scan_decoder.md
Name: seg_scan_decoder

Overview:
- Reads a multiplexed, active-low seven-segment display bus and recovers the hex nibble shown on each digit. This is the inverse of the team's hex-to-segment encoder.
- Used as a loopback checker and self-test monitor for keyboard and display experiments: it snoops the anode and segment lines and rebuilds the per-digit values.
- Adds stability filtering, per-digit valid flags, illegal-pattern error reporting and a frame-complete pulse.

Parameters:
- NDIG, 8: number of multiplexed digits (anode lines).
- STABLE, 4: consecutive identical samples of the anode and segment buses required before a digit is captured. Legal range 2..255.

Ports:
- clk  in  1  system clock, rising edge.
- clrn  in  1  asynchronous active-low reset.
- an_n  in  NDIG  digit select, active-low, expected one-hot-zero.
- seg_n  in  7  segment lines, active-low. Bit 0 = segment a, bit 6 = segment g.
- clear  in  1  synchronous clear of valid flags and frame tracking.
- values  out  4*NDIG  recovered nibbles; digit k occupies bits [4k+3:4k].
- valid  out  NDIG  per-digit flag: values[k] holds a legally decoded capture.
- err_pulse  out  1  one-cycle pulse when an illegal pattern is captured.
- err_digit  out  $clog2(NDIG)  index of the last illegal capture.
- frame_done  out  1  one-cycle pulse when every digit has been captured since the last frame.

Behaviour:
- Reset (clrn=0, asynchronous): all of the following go to 0 immediately and stay 0 while clrn=0:
  - values, valid, err_pulse, err_digit, frame_done;
  - stability counter, captured flag, frame mask, previous-sample registers.
- Sampling: an_n and seg_n are registered once (sample stage). All decisions use the registered sample and the previous registered sample.
- Active digit:
  - If exactly one bit of the registered an_n is 0, its index is the active digit k.
  - All-ones, or more than one zero: idle. Counter forced to 0, captured flag cleared, no capture.
- Stability counter:
  - Counts up while the current sample equals the previous sample (both an_n and seg_n) and the digit is active.
  - Any difference resets it to 0 and clears the captured flag.
  - Saturates at STABLE-1.
- Capture: happens once per dwell, when the counter reaches STABLE-1 and the captured flag is 0. The captured flag is then set, so no re-capture occurs until the sample changes.
- Decode table (seg_n, 7 bits, bit6..bit0 → nibble):
  - 1000000→0, 1111001→1, 0100100→2, 0110000→3
  - 0011001→4, 0010010→5, 0000010→6, 1111000→7
  - 0000000→8, 0010000→9, 0001000→A, 0000011→B
  - 1000110→C, 0100001→D, 0000110→E, 1111111→F (blank decodes to F).
- Legal capture: values[k] ← code, valid[k] ← 1, frame-mask bit k ← 1.
- Illegal capture (any other pattern):
  - values[k] unchanged, valid[k] ← 0, frame-mask bit k ← 1;
  - err_pulse=1 for one cycle, err_digit ← k.
- Latency:
  - Input change at the pins → first sample register: 1 cycle.
  - Capture outputs update on the clock edge after the STABLE-th identical registered sample.
  - Minimum pin-to-output latency: STABLE+1 cycles.
- frame_done:
  - Asserted for one cycle on the edge where the frame mask (including the bit being set) becomes all ones.
  - The mask clears on that same edge.
  - Recapturing a digit already in the mask has no extra effect.
- clear=1:
  - On the next edge, valid and the frame mask go to 0; values are retained.
  - If a capture coincides with clear, clear wins: valid and mask stay 0, values still update, err_pulse still fires, frame_done is suppressed.
- A dwell that changes before STABLE samples produces no capture. This filters ghosting during anode switching.
- STABLE samples of an unchanged pattern on a new digit index count as a change, because an_n differs.

Decomposition:
- Shared package seg_pkg:
  - the 16 SEG_PAT_x localparams (active-low patterns, shared with the encoder);
  - SEG_BLANK;
  - NIBBLE_W=4.
- One sub-module, seg_pattern_lookup:
  - combinational, seg_n[6:0] → nibble[3:0] plus legal bit;
  - built from the seg_pkg constants.
- Top module holds the sample registers, stability counter (width $clog2(STABLE)), one-hot check/priority index, value/valid storage and frame mask.

Test Plan:
- Reset: hold clrn=0 mid-capture → all outputs 0 immediately. Release, drive an_n=8'b11111110, seg_n=7'b0110000 for 6 cycles → values[3:0]=3 and valid[0]=1 at cycle STABLE+1=5, captured exactly once.
- Glitch filter: on digit 2, drive seg_n=0000010 for 3 cycles, then switch to 1111000 for 5 cycles → the 6 is never captured; values[11:8]=7 and valid[2]=1.
- Illegal pattern: on digit 5, drive seg_n=1010101 for 4+ cycles → one-cycle err_pulse, err_digit=5, valid[5]=0, values[23:20] unchanged.
- Full frame: scan digits 0..7 showing 0..7 with an 8-cycle dwell each → single frame_done pulse on digit 7's capture edge; values=32'h76543210, valid=8'hFF. A second scan produces a second pulse.
- Idle and multi-select: an_n=8'hFF, then an_n=8'b11110011, each for 10 cycles → no captures, no pulses, outputs unchanged.
- Clear collision: assert clear on the same edge as digit 7's capture, with digits 0..6 already in the mask → valid=0, no frame_done, values[31:28] updated.
